// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants.
package cpu_pkg;
  localparam int              WORD             = 32;
  localparam logic [WORD-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} fetch_state_e;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-2 DEPTH >= 2, pointers carry a wrap bit.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign count_o = wr_ptr - rd_ptr;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_ptr == rd_ptr);
  assign do_pop  = pop_i & ~empty_o;
  // a pop in the same cycle frees the slot, so push at full is fine then
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem[wr_ptr[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues imem requests under a credit
// limit, queues {pc, inst} in order and hands the head to IF/ID.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [WORD-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            redirect_i,
  input  logic [WORD-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [WORD-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [WORD-1:0] imem_rdata_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [WORD-1:0] out_inst_o,
  output logic [WORD-1:0] out_pc_o,
  output logic [WORD-1:0] out_pcplus4_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(MAX_OUTST) + 1;

  fetch_state_e    state;
  logic [WORD-1:0] fetch_pc;
  logic [PW-1:0]   outst, outst_nxt, discard;
  logic            gnt_acc, q_push, q_pop;
  logic [CW-1:0]   q_count;
  logic            q_full, q_empty, pcq_full, pcq_empty;
  logic [WORD-1:0] pcq_head;
  fetch_entry_t    q_wdata, q_head;

  assign imem_req_o  = (state == FETCH) & start_i & ~redirect_i
                     & ((32'(q_count) + 32'(outst)) < 32'(DEPTH))
                     & (32'(outst) < 32'(MAX_OUTST));
  assign imem_addr_o = fetch_pc;
  assign gnt_acc     = imem_req_o & imem_gnt_i;
  assign outst_nxt   = outst + PW'(gnt_acc) - PW'(imem_rvalid_i);

  // responses landing in a redirect cycle belong to the old path
  assign q_push  = imem_rvalid_i & (discard == '0) & ~redirect_i;
  assign q_pop   = ~q_empty & out_ready_i;
  assign q_wdata = '{pc: pcq_head, inst: imem_rdata_i};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      // everything still in flight after this edge is old-path
      discard  <= outst_nxt;
      if (state != IDLE) state <= (outst_nxt != '0) ? FLUSH : FETCH;
    end else begin
      if (gnt_acc) fetch_pc <= fetch_pc + 32'd4;
      if (imem_rvalid_i && discard != '0) discard <= discard - PW'(1);
      unique case (state)
        IDLE:    if (start_i) state <= FETCH;
        FETCH:   if (!start_i && outst == '0) state <= IDLE;
        FLUSH:   if (discard == '0 || (discard == PW'(1) && imem_rvalid_i)) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (redirect_i),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .rdata_o (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // pc side FIFO: its occupancy is the outstanding-request count
  sync_fifo #(.WIDTH(WORD), .DEPTH(MAX_OUTST)) u_pcq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (1'b0),
    .push_i  (gnt_acc),
    .wdata_i (fetch_pc),
    .pop_i   (imem_rvalid_i),
    .rdata_o (pcq_head),
    .count_o (outst),
    .full_o  (pcq_full),
    .empty_o (pcq_empty)
  );

  assign out_valid_o   = ~q_empty;
  assign out_inst_o    = out_valid_o ? q_head.inst : '0;
  assign out_pc_o      = out_valid_o ? q_head.pc : '0;
  assign out_pcplus4_o = out_valid_o ? q_head.pc + 32'd4 : '0;

  a_rvalid_outst: assert property (@(posedge clk_i) disable iff (!rst_i) imem_rvalid_i |-> !pcq_empty);
  a_gnt_credit:   assert property (@(posedge clk_i) disable iff (!rst_i) gnt_acc |-> !pcq_full);
  a_push_room:    assert property (@(posedge clk_i) disable iff (!rst_i) q_push |-> (!q_full || q_pop));
endmodule
